// File: rtl/tetris_soc_pio_in_if.sv
// Avalon-MM slave bus bundle for the parallel input port: register access plus the IRQ line.
interface tetris_soc_pio_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/tetris_soc_pio_in.sv
// Avalon-MM parallel input port: synchronized level readback, optional edge capture with
// maskable IRQ enabled by defining PIO_IN_EDGE_IRQ_EN.
module tetris_soc_pio_in #(
    parameter int WIDTH     = 4,
    parameter int EDGE_TYPE = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tetris_soc_pio_in_if.slave   bus,
    input  logic [WIDTH-1:0]     in_port
);

    // Bus semantics: no wait states. A cycle with chipselect=1 is a transfer; write_n=1 makes it
    // a read whose data appears on readdata after the next edge, write_n=0 a write committed on
    // that edge. readdata holds its value whenever no read is in progress.
    logic             rd_en;
    logic             wr_en;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [31:0]      data_ext;
    logic [31:0]      rd_mux;

    assign rd_en = bus.chipselect & bus.write_n;
    assign wr_en = bus.chipselect & ~bus.write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

    always_comb begin
        data_ext = '0;
        data_ext[WIDTH-1:0] = s2;
    end

`ifdef PIO_IN_EDGE_IRQ_EN
    logic [WIDTH-1:0] s3;
    logic [1:0]       arm_cnt;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clr;
    logic [31:0]      mask_ext;
    logic [31:0]      cap_ext;
    logic             irq_q;

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_raw = s2 & ~s3;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_raw = ~s2 & s3;
        end else begin : g_any
            assign edge_raw = s2 ^ s3;
        end
    endgenerate

    // Masking until the pipeline has filled keeps lines already high at reset from capturing.
    assign edges = (arm_cnt == 2'd3) ? edge_raw : '0;
    assign clr   = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s3          <= '0;
            arm_cnt     <= 2'd0;
            irqmask     <= '0;
            edgecapture <= '0;
            irq_q       <= 1'b0;
        end else begin
            s3 <= s2;
            if (arm_cnt != 2'd3)
                arm_cnt <= arm_cnt + 2'd1;
            if (wr_en && bus.address == 2'd2)
                irqmask <= bus.writedata[WIDTH-1:0];
            // Set has priority over clear so an edge arriving with a clear is never lost.
            edgecapture <= (edgecapture & ~clr) | edges;
            irq_q       <= |(edgecapture & irqmask);
        end
    end

    always_comb begin
        mask_ext = '0;
        mask_ext[WIDTH-1:0] = irqmask;
        cap_ext = '0;
        cap_ext[WIDTH-1:0] = edgecapture;
    end

    always_comb begin
        case (bus.address)
            2'd0:    rd_mux = data_ext;
            2'd2:    rd_mux = mask_ext;
            2'd3:    rd_mux = cap_ext;
            default: rd_mux = '0;
        endcase
    end

    assign bus.irq = irq_q;
`else
    always_comb begin
        rd_mux = (bus.address == 2'd0) ? data_ext : '0;
    end

    assign bus.irq = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bus.readdata <= '0;
        else if (rd_en)
            bus.readdata <= rd_mux;
    end

endmodule

// File: tb/tb_tetris_soc_pio_in.sv
// Self-checking bench for tetris_soc_pio_in: register table plus edge/IRQ/reset sequences,
// expectations adapt to whether PIO_IN_EDGE_IRQ_EN is defined.
module tb_tetris_soc_pio_in;

`ifdef PIO_IN_EDGE_IRQ_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  in_port;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    bit          sel_q[$];
    bit          rd_pending = 1'b0;

    tetris_soc_pio_in_if bus0 ();
    tetris_soc_pio_in_if bus2 ();

    assign bus0.address    = address;
    assign bus0.chipselect = chipselect;
    assign bus0.write_n    = write_n;
    assign bus0.writedata  = writedata;
    assign bus2.address    = address;
    assign bus2.chipselect = chipselect;
    assign bus2.write_n    = write_n;
    assign bus2.writedata  = writedata;

    tetris_soc_pio_in #(.WIDTH(4), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port)
    );

    tetris_soc_pio_in #(.WIDTH(4), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance one clock; sample 1ns after the edge and retire any read issued last cycle.
    task automatic tick();
        logic [31:0] e;
        string       n;
        bit          s;
        @(posedge clk);
        #1;
        if (rd_pending) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            s = sel_q.pop_front();
            chk(n, s ? bus2.readdata : bus0.readdata, e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input bit sel, input logic [1:0] a, input logic [31:0] e, input string nm);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        sel_q.push_back(sel);
        rd_pending = 1'b1;
        tick();
        rd_pending = 1'b0;
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  in_val;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2'd0, 32'hFFFF_FFFF, 4'h5, 32'h5};
        vecs[1] = '{2'd0, 32'h0000_0000, 4'hA, 32'hA};
        vecs[2] = '{2'd1, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vecs[3] = '{2'd2, 32'hFFFF_FFF5, 4'h0, EN ? 32'h5 : 32'h0};
        vecs[4] = '{2'd2, 32'h0000_000A, 4'h3, EN ? 32'hA : 32'h0};
        vecs[5] = '{2'd2, 32'h0000_0000, 4'hC, 32'h0};
        vecs[6] = '{2'd0, 32'h1234_5678, 4'h0, 32'h0};

        reset_n    = 1'b0;
        in_port    = 4'hF;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset with all lines high: level reads back, arming suppresses capture.
        idle(2);
        chk("reset_readdata", bus0.readdata, 32'h0);
        chk("reset_irq", {31'b0, bus0.irq}, 32'h0);
        reset_n = 1'b1;
        idle(5);
        rd(0, 2'd0, 32'hF, "armed_data");
        rd(0, 2'd3, 32'h0, "armed_no_capture");
        chk("armed_irq", {31'b0, bus0.irq}, 32'h0);
        rd(1, 2'd3, 32'h0, "armed_no_capture_any");

        in_port = 4'h0;
        idle(4);
        wr(2'd3, 32'hF);

        // Register access table.
        for (int i = 0; i < 7; i++) begin
            in_port = vecs[i].in_val;
            idle(3);
            wr(vecs[i].addr, vecs[i].wdata);
            rd(0, vecs[i].addr, vecs[i].exp, $sformatf("table_%0d", i));
        end
        idle(2);
        wr(2'd3, 32'hF);
        rd(0, 2'd3, 32'h0, "capture_cleared");

        // Data latency: new level not yet visible on the first read, visible on the next.
        in_port = 4'h0;
        idle(3);

        // Rising edge on bit0 with mask bit0: capture at N+3, irq at N+4, clear drops irq.
        wr(2'd2, 32'h1);
        in_port = 4'h1;
        tick();
        rd(0, 2'd0, 32'h0, "data_latency_old");
        rd(0, 2'd3, 32'h0, "capture_latency_early");
        chk("irq_latency_early", {31'b0, bus0.irq}, 32'h0);
        rd(0, 2'd3, EN ? 32'h1 : 32'h0, "capture_bit0");
        chk("irq_bit0", {31'b0, bus0.irq}, {31'b0, EN});
        wr(2'd3, 32'h1);
        chk("irq_clear_same_cycle", {31'b0, bus0.irq}, {31'b0, EN});
        tick();
        chk("irq_after_clear", {31'b0, bus0.irq}, 32'h0);
        rd(0, 2'd0, 32'h1, "data_bit0");

        // Unmasked edge on bit2, then enabling the mask raises irq one cycle later.
        in_port = 4'h5;
        idle(4);
        rd(0, 2'd3, EN ? 32'h4 : 32'h0, "capture_bit2_masked");
        chk("irq_masked", {31'b0, bus0.irq}, 32'h0);
        wr(2'd2, 32'h4);
        chk("irq_mask_write_edge", {31'b0, bus0.irq}, 32'h0);
        tick();
        chk("irq_after_mask", {31'b0, bus0.irq}, {31'b0, EN});

        // Edge on bit1 lands on the same edge as a write-1-to-clear of bit1.
        in_port = 4'h7;
        tick();
        tick();
        wr(2'd3, 32'h2);
        rd(0, 2'd3, EN ? 32'h6 : 32'h0, "set_wins_clear");
        wr(2'd3, 32'h2);
        rd(0, 2'd3, EN ? 32'h4 : 32'h0, "clear_bit1");

        // Any-edge instance captures both transitions of bit3; rising-only ignores the fall.
        wr(2'd3, 32'hF);
        in_port = 4'hF;
        idle(4);
        rd(1, 2'd3, EN ? 32'h8 : 32'h0, "any_rise_bit3");
        rd(0, 2'd3, EN ? 32'h8 : 32'h0, "rise_bit3");
        wr(2'd3, 32'h8);
        in_port = 4'h7;
        idle(4);
        rd(1, 2'd3, EN ? 32'h8 : 32'h0, "any_fall_bit3");
        rd(0, 2'd3, 32'h0, "rise_ignores_fall");

        // Full capture with irq high, then asynchronous reset mid-cycle.
        wr(2'd3, 32'hF);
        in_port = 4'h0;
        idle(4);
        wr(2'd3, 32'hF);
        wr(2'd2, 32'hF);
        in_port = 4'hF;
        idle(5);
        chk("irq_full", {31'b0, bus0.irq}, {31'b0, EN});
        rd(0, 2'd3, EN ? 32'hF : 32'h0, "capture_full");
        wr(2'd0, 32'h0);
        chk("readdata_hold_on_write", bus0.readdata, EN ? 32'hF : 32'h0);
        tick();
        chk("readdata_hold_idle", bus0.readdata, EN ? 32'hF : 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_irq", {31'b0, bus0.irq}, 32'h0);
        chk("midreset_readdata", bus0.readdata, 32'h0);
        chk("midreset_readdata_any", bus2.readdata, 32'h0);
        in_port = 4'h0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(4);
        rd(0, 2'd2, 32'h0, "midreset_irqmask");
        rd(0, 2'd3, 32'h0, "midreset_capture");
        chk("midreset_irq_after", {31'b0, bus0.irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
